// File: rtl/ring_slot_scheduler.sv
// Round-robin one-hot slot scheduler with a clock-enable prescaler that limits how long a requester can hold the slot.
// Optional: define RING_SCHED_PRIORITY0_EN to give requester 0 priority over the ring.
module ring_slot_scheduler #(
   parameter int unsigned N          = 8,
   parameter int unsigned DIV        = 1000000,
   parameter int unsigned SLOT_TICKS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         done,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 tick,
   output logic                 timeout
);
   localparam int unsigned OW = $clog2(N);
   localparam int unsigned PW = $clog2(DIV);
   localparam int unsigned SW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t          r_state,   w_state_nxt;
   logic [PW-1:0]   r_presc,   w_presc_nxt;
   logic            r_tick,    w_tick_nxt;
   logic [N-1:0]    r_ptr,     w_ptr_nxt;
   logic [N-1:0]    r_grant,   w_grant_nxt;
   logic [OW-1:0]   r_owner,   w_owner_nxt;
   logic            r_busy,    w_busy_nxt;
   logic [SW-1:0]   r_slot,    w_slot_nxt;
   logic            r_timeout, w_timeout_nxt;

   logic [OW-1:0]   w_ptr_idx;
   logic [OW-1:0]   w_win_idx;
   logic [N-1:0]    w_win_oh;
   logic            w_found;
   int unsigned     w_cand;
   logic            w_release;
   logic            w_expire;
   logic [N-1:0]    w_ptr_exit;

   // Winner search: first asserted req starting one position after the pointer.
   always_comb begin
      w_ptr_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (r_ptr[i]) w_ptr_idx = OW'(i);
      end
      w_found   = 1'b0;
      w_win_idx = '0;
      w_cand    = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_cand = 32'(w_ptr_idx) + k;
         if (w_cand >= N) w_cand = w_cand - N;
         if (!w_found && req[OW'(w_cand)]) begin
            w_found   = 1'b1;
            w_win_idx = OW'(w_cand);
         end
      end
`ifdef RING_SCHED_PRIORITY0_EN
      if (req[0]) begin
         w_found   = 1'b1;
         w_win_idx = '0;
      end
`endif
      w_win_oh            = '0;
      w_win_oh[w_win_idx] = 1'b1;
   end

   assign w_release = done[r_owner] | ~req[r_owner] | ~en;
   assign w_expire  = r_tick && (r_slot == SW'(SLOT_TICKS - 1));

`ifdef RING_SCHED_PRIORITY0_EN
   // Requester 0 slots leave the ring position untouched.
   assign w_ptr_exit = (r_owner == '0) ? r_ptr : r_grant;
`else
   assign w_ptr_exit = r_grant;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      w_state_nxt   = r_state;
      w_presc_nxt   = r_presc;
      w_tick_nxt    = 1'b0;
      w_ptr_nxt     = r_ptr;
      w_grant_nxt   = r_grant;
      w_owner_nxt   = r_owner;
      w_busy_nxt    = r_busy;
      w_slot_nxt    = r_slot;
      w_timeout_nxt = 1'b0;

      if (en) begin
         w_tick_nxt  = (r_presc == PW'(DIV - 1));
         w_presc_nxt = w_tick_nxt ? '0 : r_presc + PW'(1);
      end

      case (r_state)
         S_IDLE: begin
            if (en && w_found) begin
               w_grant_nxt = w_win_oh;
               w_owner_nxt = w_win_idx;
               w_busy_nxt  = 1'b1;
               w_slot_nxt  = '0;
               w_state_nxt = S_GRANT;
            end
         end
         S_GRANT: begin
            if (w_release || w_expire) begin
               w_timeout_nxt = ~w_release;
               w_ptr_nxt     = w_ptr_exit;
               w_grant_nxt   = '0;
               w_owner_nxt   = '0;
               w_busy_nxt    = 1'b0;
               w_state_nxt   = S_RELEASE;
            end else if (r_tick) begin
               w_slot_nxt = r_slot + SW'(1);
            end
         end
         S_RELEASE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_grant_nxt = '0;
            w_owner_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_presc   <= '0;
         r_tick    <= 1'b0;
         r_ptr     <= {1'b1, {(N-1){1'b0}}};
         r_grant   <= '0;
         r_owner   <= '0;
         r_busy    <= 1'b0;
         r_slot    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_presc   <= w_presc_nxt;
         r_tick    <= w_tick_nxt;
         r_ptr     <= w_ptr_nxt;
         r_grant   <= w_grant_nxt;
         r_owner   <= w_owner_nxt;
         r_busy    <= w_busy_nxt;
         r_slot    <= w_slot_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign grant   = r_grant;
   assign owner   = r_owner;
   assign busy    = r_busy;
   assign tick    = r_tick;
   assign timeout = r_timeout;

endmodule
